price_average: RTL and testbench

Sliding-window price averager sitting directly upstream of `trade_decision`. Accepts parsed 178-bit market messages, keeps a circular history of the last 2^LOG_DEPTH prices, and forwards each message unchanged together with the average of the *preceding* window. Downstream uses `average_o` to judge the forwarded message's price. Single clock; one message in flight.

---
 rtl/hft_pkg.sv | 29 ++
 rtl/price_window_ram.sv | 41 ++++
 rtl/price_average.sv | 130 +++++++++++++
 tb/tb_price_average.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// Shared market-message definitions for the trading pipeline (parser,
// price_average, trade_decision).
//
// Message layout (178 bits):
//   [177:176] type, [175:144] symbol, [143:80] price (unsigned cents),
//   [79:72] quantity, [71:0] reserved.
// No ports; constants, typedefs and a price-extraction helper only.
package hft_pkg;

   localparam int MSG_W      = 178;
   localparam int PRICE_W    = 64;

   localparam int TYPE_LSB   = 176;
   localparam int TYPE_MSB   = 177;
   localparam int SYMBOL_LSB = 144;
   localparam int SYMBOL_MSB = 175;
   localparam int PRICE_LSB  = 80;
   localparam int PRICE_MSB  = 143;
   localparam int QTY_LSB    = 72;
   localparam int QTY_MSB    = 79;

   typedef logic [MSG_W-1:0]   msg_t;
   typedef logic [PRICE_W-1:0] price_t;

   function automatic price_t msg_price(input msg_t m);
      return m[PRICE_MSB:PRICE_LSB];
   endfunction

endpackage

// File: rtl/price_window_ram.sv
// DEPTH x 64 single-port price history RAM for price_average.
// One address serves both the synchronous write and the registered read;
// the two enables are never active together. Contents are not reset.
//
// Ports:
//   clk_i    clock
//   we_i     write enable (write wdata_i at addr_i on posedge)
//   re_i     read enable (rdata_o <= mem[addr_i] on posedge)
//   addr_i   entry address
//   wdata_i  price to store
//   rdata_o  registered read data, held while re_i is low
module price_window_ram
   import hft_pkg::*;
#(
   parameter int LOG_DEPTH = 3
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic                 re_i,
   input  logic [LOG_DEPTH-1:0] addr_i,
   input  price_t               wdata_i,
   output price_t               rdata_o
);

   localparam int DEPTH = 1 << LOG_DEPTH;

   price_t mem [DEPTH];
   price_t rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/price_average.sv
// Sliding-window price averager. Accepts one parsed market message at a
// time, forwards it unchanged, and attaches the average price of the
// window of messages that preceded it.
//
// Optional build macro: PRICE_AVERAGE_WARMUP_EN -- while the window is not
// yet full, average_o reports the forwarded message's own price instead of
// the zero-padded window average.
//
// Handshakes: an input transfer happens on a posedge where v_i & ready_o;
// an output transfer happens on a posedge where yumi_i is high while v_o
// is high. v_i outside IDLE and yumi_i outside HOLD are ignored.
//
// Ports:
//   clk_i      clock
//   reset_i    synchronous active-high reset
//   v_i        input message valid
//   ready_o    block can accept a message
//   message_i  parsed message
//   v_o        output valid
//   yumi_i     consumer takes the output this cycle
//   message_o  forwarded message
//   average_o  average price of the prior window (cents)
module price_average
   import hft_pkg::*;
#(
   parameter int LOG_DEPTH = 3
) (
   input  logic   clk_i,
   input  logic   reset_i,
   input  logic   v_i,
   output logic   ready_o,
   input  msg_t   message_i,
   output logic   v_o,
   input  logic   yumi_i,
   output msg_t   message_o,
   output price_t average_o
);

   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam int SUM_W = PRICE_W + LOG_DEPTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [LOG_DEPTH-1:0] wr_ptr_q;
   logic [LOG_DEPTH:0]   count_q;
   logic [SUM_W-1:0]     sum_q;
   price_t               oldest_price;
   price_t               new_price;
   price_t               evict_price;
   logic                 window_full;

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (v_i)    state_d = CALC;
         CALC:                state_d = HOLD;
         HOLD:    if (yumi_i) state_d = IDLE;
         default:             state_d = IDLE;
      endcase
   end

   // ready_o is masked by reset so the block never advertises space while
   // reset is held, even before the state register has settled.
   assign ready_o = (state_q == IDLE) & ~reset_i;
   assign v_o     = (state_q == HOLD);

   assign new_price   = msg_price(message_o);
   assign window_full = (count_q == (LOG_DEPTH+1)'(DEPTH));
   // Until the window is full, the slot being overwritten never entered sum.
   assign evict_price = window_full ? oldest_price : '0;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q  <= '0;
         count_q   <= '0;
         sum_q     <= '0;
         message_o <= '0;
         average_o <= '0;
      end else begin
         if ((state_q == IDLE) && v_i) begin
            message_o <= message_i;
         end
         if (state_q == CALC) begin
`ifdef PRICE_AVERAGE_WARMUP_EN
            if (!window_full) begin
               average_o <= new_price;
            end else begin
               average_o <= sum_q[SUM_W-1:LOG_DEPTH];
            end
`else
            average_o <= sum_q[SUM_W-1:LOG_DEPTH];
`endif
            sum_q    <= sum_q - SUM_W'(evict_price) + SUM_W'(new_price);
            // Power-of-two depth: natural wrap of the pointer is mod DEPTH.
            wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
            if (!window_full) begin
               count_q <= count_q + (LOG_DEPTH+1)'(1);
            end
         end
      end
   end

   // The oldest entry is read at wr_ptr while idle so it is ready in CALC,
   // where the same slot is overwritten with the new price.
   price_window_ram #(
      .LOG_DEPTH (LOG_DEPTH)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (state_q == CALC),
      .re_i    (state_q == IDLE),
      .addr_i  (wr_ptr_q),
      .wdata_i (new_price),
      .rdata_o (oldest_price)
   );

endmodule

// File: tb/tb_price_average.sv
module tb_price_average;

   localparam int LOG_DEPTH = 2;
   localparam int DEPTH     = 1 << LOG_DEPTH;

   logic         clk_i = 1'b0;
   logic         reset_i = 1'b1;
   logic         v_i = 1'b0;
   logic         ready_o;
   logic [177:0] message_i = '0;
   logic         v_o;
   logic         yumi_i = 1'b0;
   logic [177:0] message_o;
   logic [63:0]  average_o;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: the window as a plain list of accepted prices,
   // plus a scoreboard of expected averages in acceptance order.
   logic [63:0] hist_q[$];
   logic [63:0] exp_q[$];

   price_average #(.LOG_DEPTH(LOG_DEPTH)) dut (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .v_i       (v_i),
      .ready_o   (ready_o),
      .message_i (message_i),
      .v_o       (v_o),
      .yumi_i    (yumi_i),
      .message_o (message_o),
      .average_o (average_o)
   );

   // clock
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [177:0] obs, input logic [177:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [177:0] make_msg(input logic [63:0] price);
      logic [191:0] r;
      logic [177:0] m;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      m = r[177:0];
      m[143:80] = price;
      return m;
   endfunction

   // Expected average for a message with this price given the current window.
   function automatic logic [63:0] model_avg(input logic [63:0] price);
      logic [65:0] s;
      s = '0;
      foreach (hist_q[i]) s = s + 66'(hist_q[i]);
`ifdef PRICE_AVERAGE_WARMUP_EN
      if (hist_q.size() < DEPTH) return price;
`endif
      return 64'(s / DEPTH);
   endfunction

   function automatic void model_push(input logic [63:0] price);
      hist_q.push_back(price);
      if (hist_q.size() > DEPTH) void'(hist_q.pop_front());
   endfunction

   // Send one message and retire it. hold = cycles yumi_i stays low in HOLD
   // (junk v_i driven meanwhile); junk_calc drives v_i during CALC.
   task automatic send(input logic [63:0] price, input int hold, input bit junk_calc,
                       output logic [63:0] got_avg);
      logic [177:0] m;
      logic [63:0]  e;
      int           t;
      t = 0;
      while (ready_o !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      chk("ready_before_accept", ready_o, 1'b1);
      m = make_msg(price);
      e = model_avg(price);
      exp_q.push_back(e);
      model_push(price);
      v_i = 1'b1;
      message_i = m;
      tick();                                   // accepting edge
      v_i = junk_calc;
      message_i = make_msg(64'($urandom));
      chk("calc_v_o", v_o, 1'b0);
      chk("calc_ready", ready_o, 1'b0);
      tick();                                   // CALC -> HOLD
      chk("hold_v_o", v_o, 1'b1);
      chk("hold_message", message_o, m);
      got_avg = average_o;
      chk("hold_average", average_o, exp_q.pop_front());
      for (int i = 0; i < hold; i++) begin
         v_i = 1'b1;
         message_i = make_msg(64'($urandom));
         tick();
         chk("bp_v_o", v_o, 1'b1);
         chk("bp_ready", ready_o, 1'b0);
         chk("bp_message", message_o, m);
         chk("bp_average", average_o, e);
      end
      v_i = 1'b0;
      yumi_i = 1'b1;
      tick();
      yumi_i = 1'b0;
      chk("post_yumi_v_o", v_o, 1'b0);
      chk("post_yumi_ready", ready_o, 1'b1);
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      v_i = 1'b0;
      yumi_i = 1'b0;
      tick();
      tick();
      hist_q.delete();
      exp_q.delete();
   endtask

   logic [63:0] avg;

   initial begin
      // Reset state.
      reset_i = 1'b1;
      tick();
      tick();
      chk("rst_v_o", v_o, 1'b0);
      chk("rst_message", message_o, '0);
      chk("rst_average", average_o, '0);
      chk("rst_ready", ready_o, 1'b0);
      reset_i = 1'b0;
      tick();
      chk("ready_after_rst", ready_o, 1'b1);

      // First two messages at 10000.
      send(64'd10000, 0, 1'b0, avg);
`ifdef PRICE_AVERAGE_WARMUP_EN
      chk("first_avg_const", avg, 64'd10000);
`else
      chk("first_avg_const", avg, 64'd0);
`endif
      send(64'd10000, 0, 1'b0, avg);
`ifndef PRICE_AVERAGE_WARMUP_EN
      chk("second_avg_const", avg, 64'd2500);
`endif

      // Window fill and wrap-around.
      do_reset();
      reset_i = 1'b0;
      tick();
      send(64'd10000, 0, 1'b0, avg);
      send(64'd10200, 0, 1'b0, avg);
      send(64'd9800,  0, 1'b0, avg);
      send(64'd10000, 0, 1'b0, avg);
      send(64'd12000, 0, 1'b0, avg);
      chk("fifth_avg_const", avg, 64'd10000);
      send(64'd10000, 0, 1'b0, avg);
      chk("wrap_avg_const", avg, 64'd10500);

      // Backpressure with a competing message on v_i, and junk v_i in CALC.
      send(64'd20000, 5, 1'b1, avg);
      send(64'd30000, 0, 1'b1, avg);

      // Reset asserted mid-CALC drops the in-flight message.
      while (ready_o !== 1'b1) tick();
      v_i = 1'b1;
      message_i = make_msg(64'd7777);
      tick();
      v_i = 1'b0;
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      hist_q.delete();
      exp_q.delete();
      chk("midcalc_v_o", v_o, 1'b0);
      chk("midcalc_message", message_o, '0);
      chk("midcalc_average", average_o, '0);
      send(64'd5000, 0, 1'b0, avg);
`ifdef PRICE_AVERAGE_WARMUP_EN
      chk("after_rst_avg_const", avg, 64'd5000);
`else
      chk("after_rst_avg_const", avg, 64'd0);
`endif

      // Spurious yumi_i while idle.
      yumi_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("spur_yumi_v_o", v_o, 1'b0);
         chk("spur_yumi_ready", ready_o, 1'b1);
      end
      yumi_i = 1'b0;
      send(64'd6000, 0, 1'b1, avg);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         logic [63:0] p;
         p = (n % 5 == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 100000));
         send(p, $urandom_range(0, 3), 1'($urandom_range(0, 1)), avg);
         for (int k = $urandom_range(0, 2); k > 0; k--) tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
      $fatal(1, "timeout");
   end

endmodule
